// File: rtl/entrada_pkg.sv
// entrada_pkg: shared types and constants for the processor input unit.
//   state_e      - FSM state encoding
//   KEY_RELEASED - debounced level of the idle (released) confirm key
//   DATA_W       - width of the word handed back to the processor
package entrada_pkg;

    localparam int unsigned DATA_W       = 32;
    localparam logic        KEY_RELEASED = 1'b1;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        ARM          = 3'd1,
        WAIT_PRESS   = 3'd2,
        WAIT_RELEASE = 3'd3,
        DONE         = 3'd4
    } state_e;

    // States in which a request is pending and the operator LED is lit.
    function automatic logic is_waiting(input state_e s);
        logic w;
        case (s)
            ARM, WAIT_PRESS, WAIT_RELEASE: w = 1'b1;
            default:                       w = 1'b0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/entrada_if.sv
// entrada_if: processor-side handshake of the input unit.
//   EnableIn     - processor executing an input instruction (master -> slave)
//   halt         - processor halted (master -> slave)
//   ValorEntrada - captured switch word (slave -> master)
//   InputReady   - one-cycle "value valid" pulse (slave -> master)
interface entrada_if;

    logic                              EnableIn;
    logic                              halt;
    logic [entrada_pkg::DATA_W-1:0]    ValorEntrada;
    logic                              InputReady;

    modport master (
        output EnableIn,
        output halt,
        input  ValorEntrada,
        input  InputReady
    );

    modport slave (
        input  EnableIn,
        input  halt,
        output ValorEntrada,
        output InputReady
    );

endinterface

// File: rtl/entrada_debounce.sv
// debounce: two-flop synchronizer plus stability counter for one key.
//   clk     - system clock
//   rst     - synchronous active-high reset
//   key_raw - asynchronous raw key level
//   key_db  - debounced level; changes only after DEBOUNCE_CYCLES stable cycles
module debounce
    import entrada_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic key_db
);

    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          key_db_q, key_db_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchronizer and stability counter next-state.
    always_comb begin
        sync1_d  = key_raw;
        sync2_d  = sync1_q;
        key_db_d = key_db_q;
        cnt_d    = cnt_q;
        if (sync2_q == key_db_q) begin
            // Any reversion to the accepted level restarts the count.
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_MAX) begin
            key_db_d = sync2_q;
            cnt_d    = {CW{1'b0}};
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Debounce registers; key idles released.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= KEY_RELEASED;
            sync2_q  <= KEY_RELEASED;
            key_db_q <= KEY_RELEASED;
            cnt_q    <= {CW{1'b0}};
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            key_db_q <= key_db_d;
            cnt_q    <= cnt_d;
        end
    end

    assign key_db = key_db_q;

endmodule

// File: rtl/entrada.sv
// entrada: processor input unit. On a request it waits for a fresh debounced
// press of the confirm key, captures the synchronized switches on the press,
// and pulses InputReady once the key is released.
//   Clock    - system clock
//   Reset    - synchronous active-high reset
//   bus      - processor handshake (EnableIn, halt, ValorEntrada, InputReady)
//   Switches - raw asynchronous board switches
//   Confirm  - raw asynchronous confirm key, active-low
//   Waiting  - request pending LED
module entrada
    import entrada_pkg::*;
#(
    parameter int unsigned SW_WIDTH        = 10,
    parameter int unsigned DEBOUNCE_CYCLES = 50000,
    parameter int unsigned SIGN_EXT        = 0
) (
    input  logic                Clock,
    input  logic                Reset,
    entrada_if.slave            bus,
    input  logic [SW_WIDTH-1:0] Switches,
    input  logic                Confirm,
    output logic                Waiting
);

    localparam int unsigned EXT_W = DATA_W - SW_WIDTH;

    logic [SW_WIDTH-1:0] sw_sync1_q, sw_sync2_q;
    logic                key_db_s;
    logic                abort_s;
    logic                fill_s;
    logic [DATA_W-1:0]   sw_ext_s;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   valor_q, valor_d;
    logic                ready_q, ready_d;
    logic                waiting_q, waiting_d;

    debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_db (
        .clk     (Clock),
        .rst     (Reset),
        .key_raw (Confirm),
        .key_db  (key_db_s)
    );

    // Switch synchronizers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sw_sync1_q <= {SW_WIDTH{1'b0}};
            sw_sync2_q <= {SW_WIDTH{1'b0}};
        end else begin
            sw_sync1_q <= Switches;
            sw_sync2_q <= sw_sync1_q;
        end
    end

    // Abort condition and width extension of the synchronized switches.
    always_comb begin
        abort_s = (!bus.EnableIn) || bus.halt;
        if (SIGN_EXT != 32'd0) begin
            fill_s = sw_sync2_q[SW_WIDTH-1];
        end else begin
            fill_s = 1'b0;
        end
        sw_ext_s = {{EXT_W{fill_s}}, sw_sync2_q};
    end

    // FSM state register.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; ARM insists on a release so a key held at
    // request time cannot satisfy the request.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!abort_s) state_d = ARM;
                else          state_d = IDLE;
            end
            ARM: begin
                if (abort_s)                        state_d = IDLE;
                else if (key_db_s == KEY_RELEASED)  state_d = WAIT_PRESS;
                else                                state_d = ARM;
            end
            WAIT_PRESS: begin
                if (abort_s)                        state_d = IDLE;
                else if (key_db_s != KEY_RELEASED)  state_d = WAIT_RELEASE;
                else                                state_d = WAIT_PRESS;
            end
            WAIT_RELEASE: begin
                if (abort_s)                        state_d = IDLE;
                else if (key_db_s == KEY_RELEASED)  state_d = DONE;
                else                                state_d = WAIT_RELEASE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: capture on the debounced press, flags track the next state
    // so both outputs line up with the state they describe.
    always_comb begin
        if ((state_q == WAIT_PRESS) && !abort_s && (key_db_s != KEY_RELEASED)) begin
            valor_d = sw_ext_s;
        end else begin
            valor_d = valor_q;
        end
        ready_d   = (state_d == DONE);
        waiting_d = is_waiting(state_d);
    end

    // Output registers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            valor_q   <= {DATA_W{1'b0}};
            ready_q   <= 1'b0;
            waiting_q <= 1'b0;
        end else begin
            valor_q   <= valor_d;
            ready_q   <= ready_d;
            waiting_q <= waiting_d;
        end
    end

    assign bus.ValorEntrada = valor_q;
    assign bus.InputReady   = ready_q;
    assign Waiting          = waiting_q;

endmodule

// File: tb/tb_entrada.sv
// tb_entrada: directed bench for entrada with DEBOUNCE_CYCLES = 4, SW_WIDTH = 10.
// Two instances share all stimulus: dut0 zero-extends, dut1 sign-extends.
module tb_entrada;
    import entrada_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       hlt;
    logic [9:0] sw;
    logic       conf;
    logic       wait0, wait1;

    int checks = 0;
    int errors = 0;
    int ir_count = 0;

    entrada_if bus0 ();
    entrada_if bus1 ();

    assign bus0.EnableIn = en;
    assign bus0.halt     = hlt;
    assign bus1.EnableIn = en;
    assign bus1.halt     = hlt;

    entrada #(.SW_WIDTH(10), .DEBOUNCE_CYCLES(4), .SIGN_EXT(0)) dut0 (
        .Clock(clk), .Reset(rst), .bus(bus0), .Switches(sw), .Confirm(conf), .Waiting(wait0)
    );

    entrada #(.SW_WIDTH(10), .DEBOUNCE_CYCLES(4), .SIGN_EXT(1)) dut1 (
        .Clock(clk), .Reset(rst), .bus(bus1), .Switches(sw), .Confirm(conf), .Waiting(wait1)
    );

    always #5 clk = ~clk;

    // Count every InputReady pulse of dut0.
    always @(negedge clk) begin
        if (bus0.InputReady === 1'b1) ir_count <= ir_count + 1;
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; hlt = 1'b0; sw = 10'd0; conf = 1'b1;
        tick(2);
        rst = 1'b0;
        checks++; if (bus0.ValorEntrada !== 32'd0) begin errors++; $display("FAIL reset_valor got %h want 0", bus0.ValorEntrada); end
        checks++; if (bus0.InputReady !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus0.InputReady); end
        checks++; if (wait0 !== 1'b0) begin errors++; $display("FAIL reset_waiting got %b want 0", wait0); end
        checks++; if (dut0.state_q !== IDLE) begin errors++; $display("FAIL reset_state got %0d want IDLE", dut0.state_q); end
        checks++; if (dut0.u_db.key_db_q !== 1'b1) begin errors++; $display("FAIL reset_key_db got %b want 1", dut0.u_db.key_db_q); end
    endtask

    task automatic test_basic_capture();
        en = 1'b1; sw = 10'd123;
        tick(2);
        checks++; if (wait0 !== 1'b1) begin errors++; $display("FAIL basic_waiting got %b want 1", wait0); end
        checks++; if (dut0.state_q !== WAIT_PRESS) begin errors++; $display("FAIL basic_wait_press got %0d want %0d", dut0.state_q, WAIT_PRESS); end
        conf = 1'b0;
        tick(6);
        checks++; if (bus0.ValorEntrada !== 32'd0) begin errors++; $display("FAIL basic_early_capture got %h want 0", bus0.ValorEntrada); end
        tick(1);
        checks++; if (bus0.ValorEntrada !== 32'd123) begin errors++; $display("FAIL basic_capture0 got %h want 7b", bus0.ValorEntrada); end
        checks++; if (bus1.ValorEntrada !== 32'd123) begin errors++; $display("FAIL basic_capture1 got %h want 7b", bus1.ValorEntrada); end
        tick(3);
        conf = 1'b1;
        tick(6);
        checks++; if (bus0.InputReady !== 1'b0 || wait0 !== 1'b1) begin errors++; $display("FAIL basic_pre_ready got ready=%b waiting=%b want 0/1", bus0.InputReady, wait0); end
        tick(1);
        checks++; if (bus0.InputReady !== 1'b1 || wait0 !== 1'b0) begin errors++; $display("FAIL basic_ready got ready=%b waiting=%b want 1/0", bus0.InputReady, wait0); end
        en = 1'b0;
        tick(1);
        checks++; if (bus0.InputReady !== 1'b0 || dut0.state_q !== IDLE) begin errors++; $display("FAIL basic_pulse_end got ready=%b state=%0d want 0/IDLE", bus0.InputReady, dut0.state_q); end
        checks++; if (bus0.ValorEntrada !== 32'd123) begin errors++; $display("FAIL basic_hold got %h want 7b", bus0.ValorEntrada); end
    endtask

    task automatic test_glitch();
        en = 1'b1; sw = 10'h3FF;
        tick(2);
        conf = 1'b0;
        tick(2);
        conf = 1'b1;
        tick(8);
        checks++; if (dut0.u_db.key_db_q !== 1'b1) begin errors++; $display("FAIL glitch_key_db got %b want 1", dut0.u_db.key_db_q); end
        checks++; if (dut0.state_q !== WAIT_PRESS) begin errors++; $display("FAIL glitch_state got %0d want %0d", dut0.state_q, WAIT_PRESS); end
        checks++; if (bus0.ValorEntrada !== 32'd123) begin errors++; $display("FAIL glitch_valor got %h want 7b", bus0.ValorEntrada); end
    endtask

    task automatic test_sign_ext();
        conf = 1'b0;
        tick(7);
        checks++; if (bus0.ValorEntrada !== 32'h000003FF) begin errors++; $display("FAIL zero_ext got %h want 000003ff", bus0.ValorEntrada); end
        checks++; if (bus1.ValorEntrada !== 32'hFFFFFFFF) begin errors++; $display("FAIL sign_ext got %h want ffffffff", bus1.ValorEntrada); end
    endtask

    task automatic test_abort_release();
        // Still in WAIT_RELEASE with the key held from the sign-extension test.
        en = 1'b0; sw = 10'd9;
        tick(1);
        checks++; if (dut0.state_q !== IDLE || wait0 !== 1'b0) begin errors++; $display("FAIL abort_rel_state got state=%0d waiting=%b want IDLE/0", dut0.state_q, wait0); end
        conf = 1'b1;
        tick(8);
        checks++; if (ir_count !== 1) begin errors++; $display("FAIL abort_rel_no_ready got %0d pulses want 1", ir_count); end
        checks++; if (bus0.ValorEntrada !== 32'h000003FF) begin errors++; $display("FAIL abort_rel_hold got %h want 000003ff", bus0.ValorEntrada); end
    endtask

    task automatic test_abort_halt();
        en = 1'b1; sw = 10'd5;
        tick(2);
        hlt = 1'b1;
        tick(1);
        checks++; if (dut0.state_q !== IDLE || wait0 !== 1'b0) begin errors++; $display("FAIL halt_state got state=%0d waiting=%b want IDLE/0", dut0.state_q, wait0); end
        conf = 1'b0;
        tick(8);
        checks++; if (dut0.state_q !== IDLE || bus0.ValorEntrada !== 32'h000003FF) begin errors++; $display("FAIL halt_hold got state=%0d valor=%h want IDLE/000003ff", dut0.state_q, bus0.ValorEntrada); end
        hlt = 1'b0; en = 1'b0; conf = 1'b1;
        tick(8);
        checks++; if (ir_count !== 1) begin errors++; $display("FAIL halt_no_ready got %0d pulses want 1", ir_count); end
    endtask

    task automatic test_held_key_back_to_back();
        conf = 1'b0;
        tick(8);
        en = 1'b1; sw = 10'd77;
        tick(3);
        checks++; if (dut0.state_q !== ARM || wait0 !== 1'b1) begin errors++; $display("FAIL held_arm got state=%0d waiting=%b want ARM/1", dut0.state_q, wait0); end
        sw = 10'd200;
        conf = 1'b1;
        tick(6);
        checks++; if (dut0.state_q !== ARM) begin errors++; $display("FAIL held_still_arm got %0d want ARM", dut0.state_q); end
        tick(1);
        checks++; if (dut0.state_q !== WAIT_PRESS || bus0.ValorEntrada !== 32'h000003FF) begin errors++; $display("FAIL held_no_capture got state=%0d valor=%h want WAIT_PRESS/000003ff", dut0.state_q, bus0.ValorEntrada); end
        conf = 1'b0;
        tick(7);
        checks++; if (bus0.ValorEntrada !== 32'd200) begin errors++; $display("FAIL held_capture got %h want c8", bus0.ValorEntrada); end
        conf = 1'b1;
        tick(7);
        checks++; if (bus0.InputReady !== 1'b1) begin errors++; $display("FAIL held_ready got %b want 1", bus0.InputReady); end
        // EnableIn left high: the unit must re-arm straight after IDLE.
        tick(2);
        checks++; if (dut0.state_q !== ARM) begin errors++; $display("FAIL b2b_rearm got %0d want ARM", dut0.state_q); end
        checks++; if (ir_count !== 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", ir_count); end
    endtask

    task automatic test_mid_reset();
        tick(1);
        sw = 10'd300;
        conf = 1'b0;
        tick(7);
        checks++; if (dut0.state_q !== WAIT_RELEASE || bus0.ValorEntrada !== 32'd300) begin errors++; $display("FAIL mid_setup got state=%0d valor=%h want WAIT_RELEASE/12c", dut0.state_q, bus0.ValorEntrada); end
        rst = 1'b1; conf = 1'b1; sw = 10'd42;
        tick(1);
        rst = 1'b0;
        checks++; if (bus0.ValorEntrada !== 32'd0 || bus0.InputReady !== 1'b0 || wait0 !== 1'b0) begin errors++; $display("FAIL mid_outputs got valor=%h ready=%b waiting=%b want 0/0/0", bus0.ValorEntrada, bus0.InputReady, wait0); end
        checks++; if (dut0.state_q !== IDLE || dut0.u_db.key_db_q !== 1'b1) begin errors++; $display("FAIL mid_state got state=%0d key_db=%b want IDLE/1", dut0.state_q, dut0.u_db.key_db_q); end
        checks++; if (bus1.ValorEntrada !== 32'd0 || wait1 !== 1'b0) begin errors++; $display("FAIL mid_dut1 got valor=%h waiting=%b want 0/0", bus1.ValorEntrada, wait1); end
        tick(2);
        conf = 1'b0;
        tick(7);
        checks++; if (bus0.ValorEntrada !== 32'd42) begin errors++; $display("FAIL mid_after_capture got %h want 2a", bus0.ValorEntrada); end
        conf = 1'b1;
        tick(7);
        checks++; if (bus0.InputReady !== 1'b1 || wait0 !== 1'b0) begin errors++; $display("FAIL mid_after_ready got ready=%b waiting=%b want 1/0", bus0.InputReady, wait0); end
        en = 1'b0;
        tick(2);
        checks++; if (ir_count !== 3) begin errors++; $display("FAIL mid_pulses got %0d want 3", ir_count); end
    endtask

    initial begin
        test_reset();
        test_basic_capture();
        test_glitch();
        test_sign_ext();
        test_abort_release();
        test_abort_halt();
        test_held_key_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/entrada.md
# entrada

Processor input unit, the counterpart of the output/display block. When the processor executes an input instruction it raises `EnableIn` and stalls. This block then waits for the operator to set the board switches and press the confirm key. It captures the switch value, presents it as a 32-bit word, and pulses `InputReady` so the processor can write it back and resume.

## Interface
Parameters:
- `SW_WIDTH`, 10: number of board switches.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles required to accept a key level change; minimum 2.
- `SIGN_EXT`, 0: 1 sign-extends the switch value from bit `SW_WIDTH-1`; 0 zero-extends it.

Ports:
- `Clock`, in, 1: single system clock.
- `Reset`, in, 1: synchronous, active-high.
- `EnableIn`, in, 1: processor is executing an input instruction; held high until `InputReady` is seen.
- `halt`, in, 1: processor halted; forces the FSM to IDLE.
- `Switches`, in, `SW_WIDTH`: raw board switches (asynchronous).
- `Confirm`, in, 1: raw confirm key (asynchronous, active-low: 0 = pressed).
- `ValorEntrada`, out, 32: captured value; holds until the next capture.
- `InputReady`, out, 1: one-cycle pulse when `ValorEntrada` is valid for the current request.
- `Waiting`, out, 1: request pending; drives the "waiting for input" LED.

## Operation
- **Synchronizers:** two-flop synchronizers on `Confirm` and on every `Switches` bit. Confirm flops reset to 1 (released); switch flops reset to 0.
- **Debounce of the synced `Confirm`:**
  - `cnt` clears whenever the synced level equals the debounced level `key_db`.
  - Otherwise `cnt` increments each cycle.
  - When `cnt == DEBOUNCE_CYCLES-1` and the synced level still differs, `key_db` takes the synced level and `cnt` clears.
  - `key_db` resets to 1.
- **FSM states and transitions:**
  - IDLE: go to ARM when `EnableIn` is 1 and `halt` is 0.
  - ARM: wait for `key_db == 1`, so a key already held at request time is never accepted. Go to WAIT_PRESS when released.
  - WAIT_PRESS: on `key_db == 0`, capture the synced switches, extended per `SIGN_EXT`, into `ValorEntrada` on that same edge. Go to WAIT_RELEASE.
  - WAIT_RELEASE: on `key_db == 1`, go to DONE.
  - DONE: `InputReady = 1` for exactly this cycle, then go to IDLE.
- **Abort:**
  - If `EnableIn` falls or `halt` rises in ARM, WAIT_PRESS, or WAIT_RELEASE, go to IDLE next cycle with no `InputReady`.
  - A value captured before an abort remains on `ValorEntrada`.
- **Outputs:**
  - `Waiting = 1` in ARM, WAIT_PRESS, and WAIT_RELEASE; registered, following state.
  - `InputReady` and `Waiting` are never 1 in the same cycle.
- **Back-to-back requests:** if `EnableIn` is still 1 in the cycle after DONE, IDLE re-arms immediately. The processor must drop `EnableIn` on `InputReady`.

## Timing
- **Reset values:** `ValorEntrada = 0`, `InputReady = 0`, `Waiting = 0`, state IDLE, `cnt = 0`, `key_db = 1`.
- **Reset mid-operation:** returns to these values on the next edge.
- **Key latency:** a key edge held stable is reflected in `key_db` 2 (sync) + `DEBOUNCE_CYCLES` edges after it appears on the pin.
  - Glitches shorter than `DEBOUNCE_CYCLES` synced cycles are ignored.
  - A level that reverts before `cnt` reaches `DEBOUNCE_CYCLES-1` resets `cnt`.
- **Press to ready:** `InputReady` rises 1 cycle after `key_db` returns to 1 in WAIT_RELEASE, i.e. the value is delivered on key release, not on press.
- **Capture timing:** `ValorEntrada` is valid from the cycle after the debounced press through at least the `InputReady` cycle.
- **Switch changes:** changes after capture do not alter `ValorEntrada`.
- **Minimum request length:** `EnableIn` rise to `InputReady` ≥ 3 cycles + 2 debounce intervals.

## Structure
- **Package `entrada_pkg`:**
  - State enum: IDLE, ARM, WAIT_PRESS, WAIT_RELEASE, DONE.
  - `KEY_RELEASED = 1'b1`.
  - Width constant 32 for `ValorEntrada`.
- **Sub-module `debounce`:** parameterized by `DEBOUNCE_CYCLES`; contains synchronizer + counter and outputs `key_db`. Instantiated once for `Confirm`.
- **Top level:** switch synchronizers, FSM, and capture register.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `SW_WIDTH = 10`.
- **Basic capture:** `Reset`; `EnableIn = 1`; `Switches = 10'd123`; press `Confirm` 10 cycles, then release. Expect `Waiting = 1` from 2 cycles after `EnableIn`, `ValorEntrada = 123` after the debounced press, and a single-cycle `InputReady` after the debounced release, with `Waiting = 0` in that cycle.
- **Glitch rejection:** `Confirm` low for 2 cycles, then high. Expect `key_db` to stay 1, no capture, and the FSM to remain in WAIT_PRESS.
- **Held key:** `Confirm` held low before `EnableIn` rises. Expect no capture until a release then a new press; the value is taken at the second press.
- **Sign extension:** `SIGN_EXT = 1`, `Switches = 10'h3FF`. Expect `ValorEntrada = 32'hFFFFFFFF`; with `SIGN_EXT = 0`, expect `32'h000003FF`.
- **Abort:** drop `EnableIn` in WAIT_RELEASE. Expect IDLE next cycle, no `InputReady`, and `ValorEntrada` keeping the captured value. Separately, `halt = 1` in WAIT_PRESS gives the same result.
- **Mid-operation reset:** assert `Reset` for 1 cycle in WAIT_RELEASE. Expect all outputs 0 and state IDLE next cycle; a later request works normally.
